// File: rtl/uart_fifo.sv
// Full-duplex UART with parametrised bit period and data width, independent RX/TX FIFOs,
// and sticky RX overrun / framing error flags. Drop-in for the legacy RS-232 device strobes.
module uart_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 RxD,
    output logic                 TxD,
    input  logic                 readRX,
    output logic                 charReady,
    output logic [DATA_BITS-1:0] RXchar,
    input  logic                 writeTX,
    input  logic [DATA_BITS-1:0] TXchar,
    output logic                 TXready,
    output logic                 TXidle,
    output logic                 rxOverrun,
    output logic                 rxFrameErr,
    input  logic                 clearErr
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- RX engine ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    state_t               rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_timer_q, rx_timer_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_push, rx_ovr_set, rx_fe_set;
    logic                 rx_overrun_q, rx_overrun_d, rx_frame_err_q, rx_frame_err_d;

    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]        rx_count_q, rx_count_d;
    logic                 rx_pop, rx_full;

    assign rx_pop  = readRX && (rx_count_q != '0);
    assign rx_full = (rx_count_q == DEPTH);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_ovr_set = 1'b0;
        rx_fe_set  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_timer_d = '0;
                rx_bit_d   = '0;
                // prev must have seen the line high, so a held-low line never retriggers
                if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_timer_q == HALF_LAST) begin
                    rx_timer_d = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BITS_LAST) rx_state_d = S_STOP;
                    else                       rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_state_d = S_IDLE;
                    if (!rx_sync_q)                rx_fe_set  = 1'b1;
                    else if (!rx_full || rx_pop)   rx_push    = 1'b1;
                    else                           rx_ovr_set = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_overrun_d   = (rx_overrun_q && !clearErr) || rx_ovr_set;
        rx_frame_err_d = (rx_frame_err_q && !clearErr) || rx_fe_set;
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_shift_q;
            rx_wr_d           = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase
    end

    assign charReady  = (rx_count_q != '0);
    assign RXchar     = charReady ? rx_mem_q[rx_rd_q] : '0;
    assign rxOverrun  = rx_overrun_q;
    assign rxFrameErr = rx_frame_err_q;

    // ---------------- TX engine ----------------
    state_t               tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d, txidle_q, txidle_d;
    logic                 tx_push, tx_pop, tx_full, tx_empty;

    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_mem_d [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]        tx_count_q, tx_count_d;

    assign tx_full  = (tx_count_q == DEPTH);
    assign tx_empty = (tx_count_q == '0);
    assign tx_push  = writeTX && !tx_full;

    // TxD is registered from the current state's level, so the line trails the FSM by one cycle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                txd_d      = 1'b1;
                tx_timer_d = '0;
                tx_bit_d   = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem_q[tx_rd_q];
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BITS_LAST) tx_state_d = S_STOP;
                    else                       tx_bit_d   = tx_bit_q + 1'b1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_bit_d   = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_mem_q[tx_rd_q];
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = TXchar;
            tx_wr_d           = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase
        // requiring IDLE on both sides delays reassertion until the stop bit has left the line
        txidle_d = (tx_state_q == S_IDLE) && (tx_state_d == S_IDLE) && (tx_count_d == '0);
    end

    assign TxD     = txd_q;
    assign TXready = !tx_full;
    assign TXidle  = txidle_q;

    // ---------------- state registers ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= S_IDLE;
            rx_timer_q     <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            rx_count_q     <= '0;
            tx_state_q     <= S_IDLE;
            tx_timer_q     <= '0;
            tx_bit_q       <= '0;
            tx_shift_q     <= '0;
            txd_q          <= 1'b1;
            txidle_q       <= 1'b1;
            tx_wr_q        <= '0;
            tx_rd_q        <= '0;
            tx_count_q     <= '0;
        end else begin
            rx_meta_q      <= RxD;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            rx_state_q     <= rx_state_d;
            rx_timer_q     <= rx_timer_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_wr_q        <= rx_wr_d;
            rx_rd_q        <= rx_rd_d;
            rx_count_q     <= rx_count_d;
            tx_state_q     <= tx_state_d;
            tx_timer_q     <= tx_timer_d;
            tx_bit_q       <= tx_bit_d;
            tx_shift_q     <= tx_shift_d;
            txd_q          <= txd_d;
            txidle_q       <= txidle_d;
            tx_wr_q        <= tx_wr_d;
            tx_rd_q        <= tx_rd_d;
            tx_count_q     <= tx_count_d;
        end
    end

    always_ff @(posedge Clock) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

endmodule
